// File: rtl/obstacle_step_scheduler.sv
// Obstacle step sequencer: programmable step period, interlocked with the draw engine.
// Define OBSTACLE_SPEED_RAMP_EN to enable the level/period difficulty ramp.
module obstacle_step_scheduler #(
    parameter int unsigned BASE_PERIOD     = 60000,
    parameter int unsigned MIN_PERIOD      = 20000,
    parameter int unsigned PERIOD_DEC      = 2000,
    parameter int unsigned STEPS_PER_LEVEL = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_state,
    input  logic        enable,
    input  logic        draw_done,
    output logic        step,
    output logic        draw_req,
    output logic [3:0]  level,
    output logic [16:0] period
);

    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_RUN  = 2'd1;
    localparam logic [1:0] GS_WIN  = 2'd2;
    localparam logic [1:0] GS_OVER = 2'd3;

    localparam logic [16:0] BASE = 17'(BASE_PERIOD);

    localparam bit PARAMS_OK = (MIN_PERIOD >= 2) && (MIN_PERIOD <= BASE_PERIOD) &&
                               (BASE_PERIOD < 131072) && (PERIOD_DEC < 131072) &&
                               (STEPS_PER_LEVEL >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("obstacle_step_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_STEP,
        S_WAIT,
        S_FROZEN
    } state_e;

    state_e      state;
    logic [16:0] cnt;
    logic [16:0] last;
    logic        at_last;
    logic        halt;
    logic        idle_req;

    assign last     = period - 17'd1;
    // >= so that a period that shrinks below the running count fires at once
    assign at_last  = (cnt >= last);
    assign halt     = (game_state == GS_WIN) || (game_state == GS_OVER);
    assign idle_req = (game_state == GS_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            step     <= 1'b0;
            draw_req <= 1'b0;
        end else if (idle_req) begin
            state    <= S_IDLE;
            cnt      <= '0;
            step     <= 1'b0;
            draw_req <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (game_state == GS_RUN) begin
                        state <= S_COUNT;
                        cnt   <= '0;
                    end
                end
                S_COUNT: begin
                    if (halt) begin
                        state    <= S_FROZEN;
                        cnt      <= '0;
                        step     <= 1'b0;
                        draw_req <= 1'b0;
                    end else if (enable) begin
                        if (at_last) begin
                            state    <= S_STEP;
                            cnt      <= '0;
                            step     <= 1'b1;
                            draw_req <= 1'b1;
                        end else begin
                            cnt <= cnt + 17'd1;
                        end
                    end
                end
                S_STEP: begin
                    if (halt) begin
                        state    <= S_FROZEN;
                        cnt      <= '0;
                        step     <= 1'b0;
                        draw_req <= 1'b0;
                    end else begin
                        step <= 1'b0;
                        if (enable) begin
                            cnt <= cnt + 17'd1;
                        end
                        if (draw_done) begin
                            state    <= S_COUNT;
                            draw_req <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (halt) begin
                        state    <= S_FROZEN;
                        cnt      <= '0;
                        step     <= 1'b0;
                        draw_req <= 1'b0;
                    end else if (draw_done && at_last) begin
                        // Late step: the redraw overran a full period, restart the count
                        state <= S_STEP;
                        cnt   <= '0;
                        step  <= 1'b1;
                    end else begin
                        if (enable) begin
                            cnt <= at_last ? last : cnt + 17'd1;
                        end
                        if (draw_done) begin
                            state    <= S_COUNT;
                            draw_req <= 1'b0;
                        end
                    end
                end
                S_FROZEN: begin
                    cnt      <= '0;
                    step     <= 1'b0;
                    draw_req <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    step     <= 1'b0;
                    draw_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef OBSTACLE_SPEED_RAMP_EN
    localparam int unsigned SCW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;
    localparam logic [SCW-1:0] STEP_LAST = SCW'(STEPS_PER_LEVEL - 1);
    localparam logic [17:0]    DEC18     = 18'(PERIOD_DEC);
    localparam logic [16:0]    MINP      = 17'(MIN_PERIOD);

    logic [SCW-1:0] step_cnt;
    logic [17:0]    dec_diff;
    logic [16:0]    next_period;
    logic           advance;

    assign dec_diff    = {1'b0, period} - DEC18;
    assign next_period = (dec_diff[17] || (dec_diff[16:0] < MINP)) ? MINP : dec_diff[16:0];
    // Only a live step counts; a freeze arriving during S_STEP leaves level/period untouched
    assign advance     = (state == S_STEP) && (game_state == GS_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            level    <= '0;
            period   <= BASE;
        end else if (idle_req) begin
            step_cnt <= '0;
            level    <= '0;
            period   <= BASE;
        end else if (advance) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                period   <= next_period;
                if (level != 4'd15) begin
                    level <= level + 4'd1;
                end
            end else begin
                step_cnt <= step_cnt + SCW'(1);
            end
        end
    end
`else
    assign level  = 4'd0;
    assign period = BASE;
`endif

endmodule

// File: tb/tb_obstacle_step_scheduler.sv
// Directed bench for obstacle_step_scheduler with a small draw-engine responder.
// Expectations follow OBSTACLE_SPEED_RAMP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_obstacle_step_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  game_state;
    logic        enable;
    logic        draw_done;
    logic        step;
    logic        draw_req;
    logic [3:0]  level;
    logic [16:0] period;

    int checks = 0;
    int errors = 0;
    int age    = 1000;
    bit auto_dd = 1'b1;

`ifdef OBSTACLE_SPEED_RAMP_EN
    localparam int EXP_INT [8] = '{11, 10, 7, 7, 4, 4, 4, 4};
    localparam int EXP_LVL [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    localparam int EXP_PER [8] = '{10, 10, 7, 7, 4, 4, 4, 4};
    localparam int HELD_LVL = 4;
    localparam int HELD_PER = 4;
`else
    localparam int EXP_INT [8] = '{11, 10, 10, 10, 10, 10, 10, 10};
    localparam int EXP_LVL [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    localparam int EXP_PER [8] = '{10, 10, 10, 10, 10, 10, 10, 10};
    localparam int HELD_LVL = 0;
    localparam int HELD_PER = 10;
`endif

    always #5 clk = ~clk;

    obstacle_step_scheduler #(
        .BASE_PERIOD     (10),
        .MIN_PERIOD      (4),
        .PERIOD_DEC      (3),
        .STEPS_PER_LEVEL (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_state (game_state),
        .enable     (enable),
        .draw_done  (draw_done),
        .step       (step),
        .draw_req   (draw_req),
        .level      (level),
        .period     (period)
    );

    // One clock; outputs observed 1 ns after the edge, draw_done answered 2 cycles after step.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (step) age = 0;
        else if (age < 1000) age++;
        if (auto_dd) draw_done = draw_req && !step && (age == 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_step(input int limit, output int n, output int nreq);
        bit found;
        found = 1'b0;
        n     = 0;
        nreq  = 0;
        for (int i = 0; i < limit && !found; i++) begin
            cyc();
            n++;
            if (step) found = 1'b1;
            else if (draw_req) nreq++;
        end
        if (!found) chk("step_timeout", 32'(step), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nreq;
        int nsteps;

        rst        = 1'b1;
        game_state = 2'd0;
        enable     = 1'b1;
        draw_done  = 1'b0;
        repeat (3) cyc();
        chk("reset_step", 32'(step), 0);
        chk("reset_req", 32'(draw_req), 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_period", 32'(period), 10);

        rst = 1'b0;
        cyc();
        chk("idle_step", 32'(step), 0);

        // Eight steps: intervals, draw_req width and the level/period ramp
        game_state = 2'd1;
        for (int k = 0; k < 8; k++) begin
            wait_step(40, n, nreq);
            chk($sformatf("interval_%0d", k + 1), n, EXP_INT[k]);
            chk($sformatf("step_req_%0d", k + 1), 32'(draw_req), 1);
            if (k > 0) chk($sformatf("req_cycles_%0d", k + 1), nreq, 2);
            chk($sformatf("level_at_%0d", k + 1), 32'(level), EXP_LVL[k]);
            chk($sformatf("period_at_%0d", k + 1), 32'(period), EXP_PER[k]);
        end

        // OVER while waiting on the redraw
        cyc();
        chk("wait_req", 32'(draw_req), 1);
        game_state = 2'd3;
        cyc();
        chk("frozen_step", 32'(step), 0);
        chk("frozen_req", 32'(draw_req), 0);
        chk("frozen_level", 32'(level), HELD_LVL);
        chk("frozen_period", 32'(period), HELD_PER);
        game_state = 2'd1;
        nsteps = 0;
        repeat (15) begin
            cyc();
            if (step || draw_req) nsteps++;
        end
        chk("frozen_stays", nsteps, 0);
        chk("frozen_level_held", 32'(level), HELD_LVL);
        game_state = 2'd0;
        cyc();
        chk("idle_level", 32'(level), 0);
        chk("idle_period", 32'(period), 10);

        // Overrun: withhold draw_done for 20 cycles
        game_state = 2'd1;
        wait_step(40, n, nreq);
        chk("ovr_first_interval", n, 11);
        auto_dd   = 1'b0;
        draw_done = 1'b0;
        nsteps    = 0;
        nreq      = 0;
        repeat (20) begin
            cyc();
            if (step) nsteps++;
            if (draw_req) nreq++;
        end
        chk("ovr_no_step", nsteps, 0);
        chk("ovr_req_held", nreq, 20);
        chk("ovr_cnt_sat", 32'(dut.cnt), 9);
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        chk("ovr_late_step", 32'(step), 1);
        auto_dd = 1'b1;

        // enable low for 5 cycles in the middle of an interval
        game_state = 2'd0;
        cyc();
        game_state = 2'd1;
        wait_step(40, n, nreq);
        chk("en_first_interval", n, 11);
        repeat (4) cyc();
        enable = 1'b0;
        repeat (5) cyc();
        enable = 1'b1;
        wait_step(40, n, nreq);
        chk("en_hold_interval", n + 9, 15);

        // Asynchronous reset while step is high
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_step", 32'(step), 0);
        chk("rst_async_req", 32'(draw_req), 0);
        chk("rst_async_period", 32'(period), 10);
        game_state = 2'd0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_step", 32'(step), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obstacle_step_scheduler.md
# obstacle_step_scheduler

Sequences obstacle movement for the runner game. Emits a one-cycle `step` pulse each time the obstacle position register should advance one pixel, replacing the free-running divider with a programmable period that shortens as the player progresses. Interlocks each step with the shared draw engine: no new step until the previous redraw completes. Sits between the game-state FSM, the obstacle position/height logic (consumer of `step`) and the draw engine (`draw_req`/`draw_done`).

## Interface
- `BASE_PERIOD`, 60000: clock cycles per step at level 0.
- `MIN_PERIOD`, 20000: floor on the period. Must satisfy 2 <= MIN_PERIOD <= BASE_PERIOD < 2^17.
- `PERIOD_DEC`, 2000: period reduction per level-up.
- `STEPS_PER_LEVEL`, 320: steps between level-ups. Must be >= 1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `game_state`  in  2  `state_t` encoding: IDLE=0, RUN=1, WIN=2, OVER=3.
- `enable`  in  1  count qualifier. Counter holds while low.
- `draw_done`  in  1  one-cycle pulse from the draw engine when the obstacle redraw is finished.
- `step`  out  1  one-cycle pulse that advances the obstacle by 1 pixel.
- `draw_req`  out  1  level. Redraw requested; held until `draw_done`.
- `level`  out  4  difficulty level, saturating at 15.
- `period`  out  17  current step period in cycles.

## Operation
- FSM states: S_IDLE, S_COUNT, S_STEP, S_WAIT, S_FROZEN. All state is registered.
- Reset values: state S_IDLE, `cnt`=0, `step_cnt`=0, `level`=0, `period`=BASE_PERIOD, `step`=0, `draw_req`=0.
- `game_state`==IDLE forces S_IDLE from any state, with all registers at their reset values.
- S_IDLE -> S_COUNT when `game_state`==RUN. `cnt` is 0 on entry.
- S_COUNT:
  - increments `cnt` on cycles where `enable` is high.
  - when `enable` is high and `cnt`==`period`-1: goes to S_STEP and sets `cnt` to 0.
  - ignores `draw_done`.
- S_STEP (exactly 1 cycle):
  - `step`=1 and `draw_req`=1.
  - `cnt` increments if `enable` is high.
  - `step_cnt` increments. When it reaches STEPS_PER_LEVEL it wraps to 0, `level` increments (saturating at 15) and `period` becomes max(`period`-PERIOD_DEC, MIN_PERIOD). Compute the subtraction with 18-bit headroom so it never underflows.
  - next state is S_COUNT if `draw_done` is high this cycle, otherwise S_WAIT.
- S_WAIT:
  - `draw_req`=1.
  - `cnt` increments when `enable` is high, saturating at `period`-1.
  - on `draw_done`: goes to S_STEP if `cnt`==`period`-1 (overrun, late step), otherwise to S_COUNT.
- `game_state` WIN or OVER in S_COUNT, S_STEP or S_WAIT -> S_FROZEN.
  - `step` and `draw_req` drop the next cycle.
  - `cnt` is cleared; `level` and `period` are held.
  - S_FROZEN exits only through IDLE.
- A `period` change takes effect on the next compare. If `cnt` already exceeds the new `period`-1, the compare uses >= and fires immediately.

## Timing
- Outputs are registered decodes of the state.
- With `enable` held high and `draw_done` arriving before `cnt` saturates, consecutive `step` pulses are exactly `period` cycles apart.
- First `step` comes `period` cycles after the first S_COUNT cycle.
- Overrun: `step` fires the cycle after `draw_done`.
- `rst` mid-operation returns all outputs to reset values immediately (asynchronously).

## Configuration
- `OBSTACLE_SPEED_RAMP_EN` defined: level and period ramp as described above.
- Not defined:
  - `period` is constant at BASE_PERIOD and `level` is constant at 0.
  - `step_cnt` logic is removed.
  - All handshake and FSM behaviour is unchanged.

## Test plan
All scenarios use BASE_PERIOD=10, MIN_PERIOD=4, PERIOD_DEC=3, STEPS_PER_LEVEL=2, `enable`=1, and `draw_done` returned 2 cycles after `draw_req` rises.
- Reset then RUN: first `step` at cycle 10 of S_COUNT, next at cycle 20. `draw_req` high 3 cycles per step.
- Ramp (macro defined): after step 2, `level`=1 and `period`=7. After step 4, `period`=4. After step 6, `period` stays 4 and `level`=3.
- Ramp (macro undefined): `period` stays 10 and `level` stays 0 across 8 steps.
- Overrun: withhold `draw_done` for 20 cycles. `cnt` saturates at 9, no `step` is emitted, and `step` fires exactly 1 cycle after `draw_done`.
- `enable` low for 5 cycles mid-count: step interval grows to 15 cycles.
- OVER during S_WAIT: `draw_req` and `step` are 0 next cycle and `level`/`period` are held. IDLE then clears `level` to 0 and `period` to 10. Assert `rst` mid-S_STEP: `step` drops asynchronously.
